mips_fetch_stage: RTL and testbench
===================================

Name: mips_fetch_stage

Overview:
Instruction-fetch stage of the MIPS datapath, directly upstream of decode and of SignExtend.
- Owns the PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with valid/ready.
- Exposes instr[15:0] as a dedicated field, wired straight into SignExtend's in16.
- Supports branch/jump redirect with flush of buffered and in-flight instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, instruction FIFO entries; legal values 2..8.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  word-aligned fetch address; equals current PC.
imem_rsp_valid  input  1  response data valid.
imem_rsp_data  input  32  fetched instruction word.
redirect_valid  input  1  taken branch/jump this cycle.
redirect_pc  input  32  new PC; bits [1:0] ignored and treated as 0.
id_valid  output  1  head of FIFO is a valid instruction for decode.
id_ready  input  1  decode accepts the head this cycle.
id_instr  output  32  head instruction.
id_pc4  output  32  PC of head instruction + 4, mod 2^32.
id_imm16  output  16  id_instr[15:0]; feeds SignExtend.in16.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc = RESET_PC, req_pc = 0, state = FETCH, FIFO count = 0.
  - During the rst cycle: imem_req_valid = 0 and id_valid = 0.
  - id_instr, id_pc4 and id_imm16 read 0 while the FIFO is empty after reset.
  - rst mid-transaction abandons any outstanding request. The next response is not dropped; the memory owner must also be reset.
- FSM states:
  - FETCH: imem_req_valid = (count < BUF_DEPTH) && !redirect_valid. imem_req_addr = pc.
    - On handshake: req_pc <= pc; pc <= pc + 4 (wraps FFFF_FFFC -> 0000_0000); state goes to WAIT.
    - While unaccepted, valid stays high and addr stays stable.
  - WAIT: imem_req_valid = 0. On imem_rsp_valid: push {imem_rsp_data, req_pc + 4}; state goes to FETCH.
  - DROP: imem_req_valid = 0. On imem_rsp_valid: discard the data; state goes to FETCH.
- At most one outstanding request. FIFO overflow is impossible by construction, because issue requires count < BUF_DEPTH and count only decreases while waiting.
- FIFO:
  - id_valid = (count != 0) && !redirect_valid.
  - Pop on id_valid && id_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Head outputs are driven from registers (no combinational path from imem_rsp_data).
- Redirect has highest priority (in the redirect_valid=1 cycle):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO flushed: count <= 0. Any pop that cycle is ignored.
  - FETCH: no request issued that cycle; stay in FETCH.
  - WAIT with imem_rsp_valid=0: go to DROP.
  - WAIT with imem_rsp_valid=1: discard the response; go to FETCH.
  - DROP: stay in DROP (still one stale response pending), unless imem_rsp_valid=1 that cycle, in which case discard it and go to FETCH.
- imem_rsp_valid in FETCH (nothing outstanding): ignored. The bench flags it as a protocol error.
- Latency and throughput: with ready=1 and a 1-cycle memory, a request accepted in cycle N is visible as id_valid in cycle N+2. Throughput is 1 instruction per 2 cycles.

Test Plan:
1. Reset then run; RESET_PC=0; memory returns 0x2008_FFFF at addr 0 and 0x3C01_F333 at addr 4; ready=1, 1-cycle response, id_ready=1 -> imem_req_addr 0x0, then 0x4. id_instr 0x2008_FFFF with id_pc4 0x4 and id_imm16 0xFFFF, then 0x3C01_F333 with id_pc4 0x8 and id_imm16 0xF333. No duplicates or gaps.
2. Decode stall: id_ready=0 for 10 cycles -> exactly BUF_DEPTH (2) entries buffered, imem_req_valid drops to 0, and id_instr holds the first word. On release, words drain in order; pc resumes at 0x8.
3. Memory backpressure: imem_req_ready=0 for 3 cycles while in FETCH -> imem_req_valid stays 1 and imem_req_addr stays stable. pc advances only on the handshake cycle.
4. Redirect while WAIT with no response: redirect_pc=0x0000_0103 -> FIFO empty next cycle. The stale response is discarded (never seen on id_*). The next request address is 0x0000_0100, and its instruction has id_pc4 0x0000_0104.
5. Redirect coinciding with a response, and with a pop, in the same cycle -> response discarded, state FETCH, id_valid low in that cycle. The next issued address is the redirect target.
6. Wrap and reset mid-operation: RESET_PC=0xFFFF_FFFC -> second fetch address is 0x0000_0000 and first id_pc4 is 0x0000_0000. Asserting rst with 2 buffered entries -> id_valid=0 next cycle and the next fetch address equals RESET_PC.

Source files
------------

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
//   Instruction-fetch stage of the MIPS datapath. Owns the PC, issues one
//   word request at a time to instruction memory, buffers returned words in a
//   small FIFO and presents the head to decode. A taken branch/jump redirects
//   the PC and flushes both buffered and in-flight instructions.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high. The valid side holds its payload stable until the transfer.
//   The response channel has no ready; a response is consumed when it arrives.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request (addr == current PC)
//   imem_rsp_valid/data              fetch response
//   redirect_valid/pc                taken branch/jump, new PC (bits [1:0] ignored)
//   id_valid/ready                   FIFO head handshake towards decode
//   id_instr, id_pc4, id_imm16       head instruction, its PC+4, instr[15:0]
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm16
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

  // FETCH: may issue. WAIT: one good request outstanding.
  // DROP: one request outstanding whose response must be thrown away.
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        instr_q [BUF_DEPTH];
  logic [31:0]        pc4_q   [BUF_DEPTH];

  logic req_hs;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  // Redirect suppresses both outgoing valids in its cycle, so no request is
  // issued to a stale PC and nothing stale is handed to decode.
  assign imem_req_valid = !rst && (state_q == S_FETCH) && (cnt_q < DEPTH_C)
                          && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign id_valid       = !rst && (cnt_q != '0) && !redirect_valid;

  assign req_hs = imem_req_valid && imem_req_ready;
  assign pop    = id_valid && id_ready;
  assign push   = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

  // Head outputs come from registers only; read as zero while empty.
  assign id_instr = (cnt_q != '0) ? instr_q[rd_ptr_q] : 32'h0;
  assign id_pc4   = (cnt_q != '0) ? pc4_q[rd_ptr_q]   : 32'h0;
  assign id_imm16 = id_instr[15:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    case (state_q)
      S_FETCH: begin
        if (req_hs) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid)      state_d = S_FETCH;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_q[wr_ptr_q] <= imem_rsp_data;
      pc4_q[wr_ptr_q]   <= req_pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage. A main instance (RESET_PC = 0) is checked by a
// cycle table, a scoreboard fed by a 1-cycle memory model, and hand-written
// redirect/reset sequences. A second instance (RESET_PC = FFFF_FFFC) shares
// all inputs and is used for the PC wrap case.
module tb_mips_fetch_stage;

  localparam int DEPTH = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;

  logic        imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_instr, id_pc4;
  logic [15:0] id_imm16;

  logic        w_req_valid, w_id_valid;
  logic [31:0] w_req_addr, w_id_instr, w_id_pc4;
  logic [15:0] w_id_imm16;

  mips_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_imm16(id_imm16)
  );

  mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(w_id_valid), .id_ready(id_ready),
    .id_instr(w_id_instr), .id_pc4(w_id_pc4), .id_imm16(w_id_imm16)
  );

  // stimulus configuration applied at each falling edge
  logic        cfg_rst = 1'b1, cfg_ready = 1'b1, cfg_id_ready = 1'b1;
  logic        cfg_redir = 1'b0, cfg_hold = 1'b0;
  logic [31:0] cfg_redir_pc = 32'h0;

  // memory model and scoreboard state
  logic        mem_pend = 1'b0, mem_stale = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] model_pc = 32'h0;
  logic [63:0] exp_q[$];

  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h2008_FFFF;
    else if (a == 32'h4) return 32'h3C01_F333;
    else                 return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // One clock cycle: drive at negedge, observe 1 time unit later, and update
  // the memory model / expected queue with what the next edge will commit.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    rst            = cfg_rst;
    imem_req_ready = cfg_ready;
    id_ready       = cfg_id_ready;
    redirect_valid = cfg_redir;
    redirect_pc    = cfg_redir_pc;
    imem_rsp_valid = mem_pend && !cfg_hold && !cfg_rst;
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : 32'h0;
    #1;
    if (rst) begin
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
      exp_q.delete();
      mem_pend  = 1'b0;
      mem_stale = 1'b0;
      model_pc  = 32'h0;
    end else begin
      chk("id_valid", {31'h0, id_valid},
          {31'h0, (exp_q.size() != 0) && !redirect_valid});
      chk("req_valid", {31'h0, imem_req_valid},
          {31'h0, !mem_pend && (exp_q.size() < DEPTH) && !redirect_valid});
      if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop_empty: got %h expected no instruction", id_instr);
        end else begin
          e = exp_q.pop_front();
          chk("id_instr", id_instr, e[63:32]);
          chk("id_pc4", id_pc4, e[31:0]);
          chk("id_imm16", {16'h0, id_imm16}, {16'h0, e[47:32]});
        end
      end
      if (imem_rsp_valid) begin
        if (!redirect_valid && !mem_stale)
          exp_q.push_back({imem_rsp_data, mem_addr + 32'd4});
        mem_pend  = 1'b0;
        mem_stale = 1'b0;
      end else if (redirect_valid && mem_pend) begin
        mem_stale = 1'b1;
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_pend  = 1'b1;
        mem_addr  = imem_req_addr;
        model_pc  = model_pc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        idr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic rdy, input logic idr,
                         input logic rv, input logic [31:0] addr,
                         input logic iv, input logic [31:0] instr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.idr = idr;
    v.e_rv = rv; v.e_addr = addr; v.e_iv = iv; v.e_instr = instr;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    vec_t v;

    // Basic flow: two words, 1-cycle memory, decode always ready.
    add_vec(1, 1, 1, 0, 32'h0, 0, 32'h0);
    add_vec(1, 1, 1, 0, 32'h0, 0, 32'h0);
    add_vec(0, 1, 1, 1, 32'h0, 0, 32'h0);
    add_vec(0, 1, 1, 0, 32'h0, 0, 32'h0);
    add_vec(0, 1, 1, 1, 32'h4, 1, 32'h2008_FFFF);
    add_vec(0, 1, 1, 0, 32'h0, 0, 32'h0);
    add_vec(0, 1, 1, 1, 32'h8, 1, 32'h3C01_F333);
    add_vec(0, 1, 1, 0, 32'h0, 0, 32'h0);
    // Decode stall for 10 cycles from a fresh reset: FIFO fills to 2.
    add_vec(1, 1, 1, 0, 32'h0, 0, 32'h0);
    add_vec(0, 1, 0, 1, 32'h0, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'h0, 0, 32'h0);
    add_vec(0, 1, 0, 1, 32'h4, 1, 32'h2008_FFFF);
    add_vec(0, 1, 0, 0, 32'h0, 1, 32'h2008_FFFF);
    for (int i = 0; i < 6; i++) add_vec(0, 1, 0, 0, 32'h0, 1, 32'h2008_FFFF);
    // Release: drain in order, fetch resumes at 0x8.
    add_vec(0, 1, 1, 0, 32'h0, 1, 32'h2008_FFFF);
    add_vec(0, 1, 1, 1, 32'h8, 1, 32'h3C01_F333);
    add_vec(0, 1, 1, 0, 32'h0, 0, 32'h0);
    add_vec(0, 1, 1, 1, 32'hC, 1, mem_word(32'h8));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cfg_rst = v.rst; cfg_ready = v.rdy; cfg_id_ready = v.idr; cfg_redir = 1'b0;
      cycle();
      chk($sformatf("tbl%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, v.e_rv});
      if (v.e_rv) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, v.e_addr);
      chk($sformatf("tbl%0d_id_valid", i), {31'h0, id_valid}, {31'h0, v.e_iv});
      if (v.e_iv) chk($sformatf("tbl%0d_id_instr", i), id_instr, v.e_instr);
      if (i == 2) chk("empty_after_reset_instr", id_instr, 32'h0);
    end

    // Memory backpressure: request held stable for 3 cycles.
    cfg_ready = 1'b0; cfg_id_ready = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_req_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("bp_req_addr", imem_req_addr, 32'h10);
    end
    cfg_ready = 1'b1;
    cycle();
    chk("bp_hs_addr", imem_req_addr, 32'h10);
    cycle();
    cycle();
    chk("bp_next_addr", imem_req_addr, 32'h14);

    // Redirect while waiting with no response yet.
    cfg_hold = 1'b1; cfg_redir = 1'b1; cfg_redir_pc = 32'h0000_0103;
    cycle();
    cfg_redir = 1'b0;
    cycle();
    chk("rd_wait_flush", {31'h0, id_valid}, 32'h0);
    chk("rd_wait_drop_noreq", {31'h0, imem_req_valid}, 32'h0);
    cfg_hold = 1'b0;
    cycle();
    chk("rd_wait_stale_hidden", {31'h0, id_valid}, 32'h0);
    cycle();
    chk("rd_wait_target", imem_req_addr, 32'h0000_0100);
    cycle();
    cycle();
    chk("rd_wait_pc4", id_pc4, 32'h0000_0104);

    // Redirect coinciding with a response and a pop.
    cfg_id_ready = 1'b0;
    budget = 20;
    while (!(exp_q.size() == 1 && mem_pend) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) timeout_fail("rd_rsp_setup");
    cfg_id_ready = 1'b1; cfg_redir = 1'b1; cfg_redir_pc = 32'h0000_0200;
    cycle();
    chk("rd_rsp_id_valid", {31'h0, id_valid}, 32'h0);
    cfg_redir = 1'b0;
    cycle();
    chk("rd_rsp_target_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rd_rsp_target_addr", imem_req_addr, 32'h0000_0200);
    chk("rd_rsp_empty", {31'h0, id_valid}, 32'h0);

    // Reset with two buffered entries, then the PC-wrap instance.
    cfg_id_ready = 1'b0;
    budget = 20;
    while (exp_q.size() != 2 && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) timeout_fail("rst_full_setup");
    cfg_rst = 1'b1;
    cycle();
    cfg_rst = 1'b0; cfg_id_ready = 1'b1;
    cycle();
    chk("rst_mid_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_mid_instr_zero", id_instr, 32'h0);
    chk("rst_mid_addr", imem_req_addr, 32'h0);
    chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
    cycle();
    cycle();
    chk("wrap_second_valid", {31'h0, w_req_valid}, 32'h1);
    chk("wrap_second_addr", w_req_addr, 32'h0000_0000);
    chk("wrap_id_valid", {31'h0, w_id_valid}, 32'h1);
    chk("wrap_id_pc4", w_id_pc4, 32'h0000_0000);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
